imm_extend_pipe: RTL and testbench

Registered, parametrised immediate generator for the RV32I/RV64I decode path. It extends the combinational I/S/B/J extender in three ways: U-type and CSR-zimm formats, XLEN-generic sign extension, and a valid/ready pipeline stage with a 2-entry skid buffer. It sits between the decode and execute stages of the multi-cycle core, carrying a tag alongside each immediate.

---
 rtl/imm_extend_pipe.sv | 107 ++++++++++
 tb/tb_imm_extend_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// RV32I/RV64I immediate generator with a valid/ready output stage and a 2-entry skid buffer; 1-cycle latency.
// Backpressure: in_ready = !skid_valid; optional reserved-format flag out_err under IMMEXT_ERR_EN.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag
`ifdef IMMEXT_ERR_EN
  ,
  output logic             out_err
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
`ifdef IMMEXT_ERR_EN
    logic             err;
`endif
  } entry_t;

  logic [31:0]        imm32;
  logic               sext;
  logic signed [32:0] ext33;
  entry_t             new_ent;
  entry_t             main_ent;
  entry_t             skid_ent;
  logic               main_vld;
  logic               skid_vld;
  logic               acc;
  logic               xfer;

  // instr carries word bits [31:7], so word bit b lives at instr[b-7].
  always_comb begin
    imm32 = '0;
    sext  = 1'b1;
    case (immsrc)
      3'b000:  imm32 = {{20{instr[24]}}, instr[24:13]};
      3'b001:  imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      3'b010:  imm32 = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      3'b011:  imm32 = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      3'b100:  imm32 = {instr[24:5], 12'b0};
      3'b101:  begin
        imm32 = {27'b0, instr[12:8]};
        sext  = 1'b0;
      end
      default: begin
        imm32 = '0;
        sext  = 1'b0;
      end
    endcase
  end

  assign ext33 = {sext & imm32[31], imm32};

  always_comb begin
    new_ent     = '0;
    new_ent.imm = XLEN'(ext33);
    new_ent.tag = in_tag;
`ifdef IMMEXT_ERR_EN
    new_ent.err = immsrc[2] & immsrc[1];
`endif
  end

  assign in_ready  = !skid_vld;
  assign out_valid = main_vld;
  assign immext    = main_ent.imm;
  assign out_tag   = main_ent.tag;
`ifdef IMMEXT_ERR_EN
  assign out_err   = main_ent.err;
`endif

  assign acc  = in_valid && in_ready;
  assign xfer = main_vld && out_ready;

  // acc implies the skid is empty, so the skid-drain branch never races a new accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      main_ent <= '0;
      skid_ent <= '0;
    end else if (skid_vld && xfer) begin
      main_ent <= skid_ent;
      skid_vld <= 1'b0;
    end else if (acc && main_vld && !xfer) begin
      skid_ent <= new_ent;
      skid_vld <= 1'b1;
    end else if (acc) begin
      main_ent <= new_ent;
      main_vld <= 1'b1;
    end else if (xfer) begin
      main_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [24:0] instr;
  logic [2:0]  immsrc;
  logic [4:0]  in_tag;
  logic        rdy32, rdy64, ov32, ov64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [4:0]  tag32, tag64;
`ifdef IMMEXT_ERR_EN
  logic        err32, err64;
`endif

  imm_extend_pipe #(.XLEN(32), .TAG_W(5)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .immext(imm32), .out_tag(tag32)
`ifdef IMMEXT_ERR_EN
    , .out_err(err32)
`endif
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .immext(imm64), .out_tag(tag64)
`ifdef IMMEXT_ERR_EN
    , .out_err(err64)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference immediate built from the format field layout, XLEN=64 view.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src);
    logic [63:0] u;
    logic [63:0] sgn;
    u   = {32'b0, w};
    sgn = w[31] ? '1 : '0;
    case (src)
      3'd0: return (sgn << 12) | (u >> 20);
      3'd1: return (sgn << 12) | (((u >> 25) & 127) << 5) | ((u >> 7) & 31);
      3'd2: return (sgn << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                   | (((u >> 8) & 15) << 1);
      3'd3: return (sgn << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                   | (((u >> 21) & 1023) << 1);
      3'd4: return (sgn << 32) | (u & 64'hFFFF_F000);
      3'd5: return (u >> 15) & 31;
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] w;
    logic [2:0]  src;
    logic [31:0] x32;
    logic [63:0] x64;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] e64;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  vec_t vt[12];
  exp_t q[$];

  task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] src, input logic [4:0] t);
    in_valid = v;
    instr    = w[31:7];
    immsrc   = src;
    in_tag   = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string name, input logic [31:0] x32, input logic [63:0] x64,
                         input logic [4:0] t, input logic e);
    chk({name, " out_valid32"}, {63'b0, ov32}, 64'd1);
    chk({name, " out_valid64"}, {63'b0, ov64}, 64'd1);
    chk({name, " immext32"}, {32'b0, imm32}, {32'b0, x32});
    chk({name, " immext64"}, imm64, x64);
    chk({name, " tag32"}, {59'b0, tag32}, {59'b0, t});
    chk({name, " tag64"}, {59'b0, tag64}, {59'b0, t});
`ifdef IMMEXT_ERR_EN
    chk({name, " err32"}, {63'b0, err32}, {63'b0, e});
    chk({name, " err64"}, {63'b0, err64}, {63'b0, e});
`else
    if (e === 1'bx) $display("unreachable");
`endif
  endtask

  initial begin
    int n;
    logic [4:0]  got[8];
    logic        hold;
    logic [63:0] h_imm;
    logic [4:0]  h_tag;
    logic        acc;
    exp_t        e;

    vt[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[1]  = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
    vt[2]  = '{32'h123450B7, 3'd4, 32'h12345000, 64'h0000000012345000, 1'b0};
    vt[3]  = '{32'h800000B7, 3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    vt[4]  = '{32'h0001D073, 3'd5, 32'h00000003, 64'h0000000000000003, 1'b0};
    vt[5]  = '{32'h0020A423, 3'd1, 32'h00000008, 64'h0000000000000008, 1'b0};
    vt[6]  = '{32'hFF9FF06F, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0};
    vt[7]  = '{32'hFFFFFFFF, 3'd7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vt[8]  = '{32'h7FF00013, 3'd0, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    vt[9]  = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 64'h0000000000000000, 1'b1};
    vt[10] = '{32'hFFFFFFFF, 3'd5, 32'h0000001F, 64'h000000000000001F, 1'b0};
    vt[11] = '{32'hFE000FA3, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};

    out_ready = 1'b1;
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset out_valid", {62'b0, ov32, ov64}, 64'd0);
    chk("reset in_ready", {62'b0, rdy32, rdy64}, 64'd3);
    chk("reset immext", imm64 | {32'b0, imm32}, 64'd0);
    chk("reset tag", {54'b0, tag32, tag64}, 64'd0);
`ifdef IMMEXT_ERR_EN
    chk("reset err", {62'b0, err32, err64}, 64'd0);
`endif
    rst_n = 1'b1;

    // Back-to-back vectors with out_ready high: each one shows up the next cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vt[i].w, vt[i].src, 5'(i + 1));
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), vt[i].x32, vt[i].x64, 5'(i + 1), vt[i].err);
      chk($sformatf("vec%0d model", i), ref_imm(vt[i].w, vt[i].src), vt[i].x64);
    end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    @(negedge clk);
    chk("empty out_valid", {63'b0, ov32}, 64'd0);
    chk("empty hold immext", imm64, vt[11].x64);

    // Backpressure: fill main + skid, third item must wait upstream.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd1);
    @(negedge clk);
    chk("bp first tag", {59'b0, tag32}, 64'd1);
    chk("bp first in_ready", {63'b0, rdy32}, 64'd1);
    drive(1'b1, 32'h123450B7, 3'd4, 5'd2);
    @(negedge clk);
    chk("bp full in_ready", {62'b0, rdy32, rdy64}, 64'd0);
    drive(1'b1, 32'h0001D073, 3'd5, 5'd3);
    @(negedge clk);
    chk("bp stall in_ready", {63'b0, rdy32}, 64'd0);
    chk("bp stable tag", {59'b0, tag32}, 64'd1);
    chk("bp stable imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (ov32 && n < 8) begin
        got[n] = tag32;
        n++;
      end
      acc = in_valid && rdy32;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    chk("bp drain count", 64'(n), 64'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("bp order%0d", k), {59'b0, got[k]}, 64'(k + 1));

    // Reset while two items are buffered discards them.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd0, 5'd7);
    @(negedge clk);
    drive(1'b1, 32'hFE000EE3, 3'd2, 5'd8);
    @(negedge clk);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    chk("prereset full", {62'b0, ov32, rdy32}, 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset out_valid", {62'b0, ov32, ov64}, 64'd0);
    chk("midreset in_ready", {62'b0, rdy32, rdy64}, 64'd3);
    chk("midreset immext", imm64 | {32'b0, imm32}, 64'd0);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ov32 || ov64) n++;
    end
    chk("midreset no emit", 64'(n), 64'd0);

    // Random traffic against a FIFO scoreboard.
    do_reset();
    hold = 1'b0;
    h_imm = '0;
    h_tag = '0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd out_valid", {62'b0, ov32, ov64}, (q.size() > 0) ? 64'd3 : 64'd0);
      chk("rnd in_ready", {62'b0, rdy32, rdy64}, (q.size() < 2) ? 64'd3 : 64'd0);
      if (hold) begin
        chk("rnd stable imm", imm64, h_imm);
        chk("rnd stable tag", {59'b0, tag32}, {59'b0, h_tag});
      end
      drive(($urandom_range(0, 9) < 7), $urandom, 3'($urandom_range(0, 7)), 5'($urandom));
      out_ready = ($urandom_range(0, 9) < 6);
      if (ov32 && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk_out("rnd", e.e64[31:0], e.e64, e.tag, e.err);
      end
      if (in_valid && rdy32) begin
        e.e64 = ref_imm({instr, 7'b0}, immsrc);
        e.tag = in_tag;
        e.err = (immsrc >= 3'd6);
        q.push_back(e);
      end
      hold  = ov64 && !out_ready;
      h_imm = imm64;
      h_tag = tag32;
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
